buffer_controller: RTL

BUFFER_CONTROLLER -- requirements
Module: buffer_controller

---
 rtl/buffer_controller_pkg.sv | 23 ++
 rtl/wrap_ptr.sv | 41 ++++
 rtl/buffer_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/buffer_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buffer_controller_pkg
// Description : Shared state encoding and parameter defaults for the
//               buffer controller and its pointer sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package buffer_controller_pkg;

   // Controller phases: empty, prefilling, streaming to the consumer
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int c_DEFAULT_SIZE      = 16;
   localparam int c_DEFAULT_K         = 4;
   localparam int c_DEFAULT_J         = 4;
   localparam int c_DEFAULT_START_LVL = 8;

endpackage
`default_nettype wire

// File: rtl/wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module      : wrap_ptr
// Description : Modulo-SIZE address register that advances by a fixed STEP.
//               SIZE is a power of two, so wrap is the natural overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_ptr
   import buffer_controller_pkg::*;
#(
   parameter int SIZE = c_DEFAULT_SIZE,
   parameter int STEP = c_DEFAULT_K,
   parameter int BIT  = $clog2(SIZE)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_clr,
   input  logic           i_adv,
   output logic [BIT-1:0] o_ptr
);

   // A step equal to SIZE folds to zero, leaving the pointer in place
   localparam logic [BIT-1:0] c_STEP = BIT'(STEP % SIZE);

   logic [BIT-1:0] r_ptr;

   // Pointer register: async clear, sync clear, then advance on demand
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= r_ptr + c_STEP;
      end
   end

   assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/buffer_controller.sv
`default_nettype none
// ============================================================================
// Module      : buffer_controller
// Description : Occupancy, address and prefill control for a circular buffer
//               written K words at a time and read J words at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_controller
   import buffer_controller_pkg::*;
#(
   parameter int SIZE      = c_DEFAULT_SIZE,
   parameter int K         = c_DEFAULT_K,
   parameter int J         = c_DEFAULT_J,
   parameter int START_LVL = c_DEFAULT_START_LVL,
   parameter int BIT       = $clog2(SIZE),
   parameter int CBIT      = $clog2(SIZE + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            wr_req,
   output logic            wr_ready,
   input  logic            rd_req,
   output logic            rd_valid,
   output logic            ld,
   output logic [BIT-1:0]  write_add,
   output logic [BIT-1:0]  read_add,
   output logic [CBIT-1:0] count,
   output logic [1:0]      state
);

   localparam logic [CBIT-1:0] c_SIZE_W  = CBIT'(SIZE);
   localparam logic [CBIT-1:0] c_K_W     = CBIT'(K);
   localparam logic [CBIT-1:0] c_J_W     = CBIT'(J);
   localparam logic [CBIT-1:0] c_START_W = CBIT'(START_LVL);

   state_t          r_state;
   state_t          w_state_next;
   logic [CBIT-1:0] r_count;
   logic [CBIT-1:0] w_count_next;
   logic            w_wr_fire;
   logic            w_rd_fire;

   // Handshakes look only at the registered count; no same-cycle credit
   assign wr_ready  = ((c_SIZE_W - r_count) >= c_K_W) && !flush;
   assign rd_valid  = (r_state == STREAM) && (r_count >= c_J_W) && !flush;
   // Reset term keeps the load strobe quiet while reset is held
   assign w_wr_fire = wr_req && wr_ready && rst;
   assign w_rd_fire = rd_req && rd_valid;
   assign ld        = w_wr_fire;

   // Next occupancy; add before subtract so the intermediate never underflows
   always_comb begin
      w_count_next = r_count;
      if (w_wr_fire) begin
         w_count_next = w_count_next + c_K_W;
      end
      if (w_rd_fire) begin
         w_count_next = w_count_next - c_J_W;
      end
   end

   // Occupancy register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: empty detection wins over the low-level fallback to FILL
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_wr_fire) begin
                  w_state_next = FILL;
               end
            end
            FILL: begin
               if (w_count_next >= c_START_W) begin
                  w_state_next = STREAM;
               end
            end
            STREAM: begin
               if (w_count_next == '0) begin
                  w_state_next = IDLE;
               end else if (w_count_next < c_J_W) begin
                  w_state_next = FILL;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   wrap_ptr #(
      .SIZE (SIZE),
      .STEP (K),
      .BIT  (BIT)
   ) u_write_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (flush),
      .i_adv (w_wr_fire),
      .o_ptr (write_add)
   );

   wrap_ptr #(
      .SIZE (SIZE),
      .STEP (J),
      .BIT  (BIT)
   ) u_read_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (flush),
      .i_adv (w_rd_fire),
      .o_ptr (read_add)
   );

   assign count = r_count;
   assign state = r_state;

endmodule
`default_nettype wire
